// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_IOWAIT = 3'd2,
        ST_SETTLE = 3'd3,
        ST_HALTED = 3'd4
    } pc_state_e;

    localparam logic [2:0] CLS_SEQ    = 3'd0;
    localparam logic [2:0] CLS_JUMP   = 3'd1;
    localparam logic [2:0] CLS_BRANCH = 3'd2;
    localparam logic [2:0] CLS_JREG   = 3'd3;
    localparam logic [2:0] CLS_HALT   = 3'd4;
    localparam logic [2:0] CLS_IOWAIT = 3'd5;

    localparam logic [1:0] PC_HOLD = 2'd0;
    localparam logic [1:0] PC_INC  = 2'd1;
    localparam logic [1:0] PC_LOAD = 2'd2;

endpackage

// File: rtl/pc_settle_timer.sv
// Settle counter: cleared on load, counts while enabled, flags the last settle cycle.
module pc_settle_timer #(
    parameter int DELAY_CYCLES = 150
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic done
);
    localparam int CNT_W = $clog2(DELAY_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == LAST);

endmodule

// File: rtl/pc_sequencer.sv
// Drives the program counter's flagPC/newAddress from the decoded instruction class,
// including halt handling and a fixed settle delay after I/O completion.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W       = 20,
    parameter int DELAY_CYCLES = 150
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              instrValid,
    input  logic [2:0]        instrClass,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] immTarget,
    input  logic [ADDR_W-1:0] regTarget,
    input  logic              ioReady,
    output logic [1:0]        flagPC,
    output logic [ADDR_W-1:0] newAddress,
    output logic              pcReset,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);
    pc_state_e state_q, state_d;
    logic      illegal_q, illegal_d;
    logic      tmr_load, tmr_done;

    pc_settle_timer #(.DELAY_CYCLES(DELAY_CYCLES)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (tmr_load),
        .enable (state_q == ST_SETTLE && !tmr_done),
        .done   (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        flagPC     = PC_HOLD;
        newAddress = '0;
        tmr_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    illegal_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (instrValid) begin
                    case (instrClass)
                        CLS_SEQ:    flagPC = PC_INC;
                        CLS_JUMP: begin
                            flagPC     = PC_LOAD;
                            newAddress = immTarget;
                        end
                        CLS_BRANCH: begin
                            if (branchTaken) begin
                                flagPC     = PC_LOAD;
                                newAddress = immTarget;
                            end else begin
                                flagPC = PC_INC;
                            end
                        end
                        CLS_JREG: begin
                            flagPC     = PC_LOAD;
                            newAddress = regTarget;
                        end
                        CLS_HALT:   state_d = ST_HALTED;
                        CLS_IOWAIT: state_d = ST_IOWAIT;
                        default: begin
                            // reserved classes still advance so the program keeps moving
                            flagPC    = PC_INC;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_IOWAIT: begin
                if (ioReady) begin
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    flagPC  = PC_INC;
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign pcReset = (state_q == ST_IDLE);
    assign busy    = (state_q == ST_RUN) || (state_q == ST_IOWAIT) || (state_q == ST_SETTLE);
    assign halted  = (state_q == ST_HALTED);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer; two instances (long and minimal settle)
// run on shared stimulus and are compared against a cycle-indexed behavioural model.
module tb_pc_sequencer;
    localparam int AW = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          instrValid = 1'b0;
    logic [2:0]    instrClass = 3'd0;
    logic          branchTaken = 1'b0;
    logic [AW-1:0] immTarget = '0;
    logic [AW-1:0] regTarget = '0;
    logic          ioReady = 1'b0;

    logic [1:0]    flag_a, flag_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          pcr_a, pcr_b, busy_a, busy_b, halt_a, halt_b, ill_a, ill_b;

    pc_sequencer #(.ADDR_W(AW), .DELAY_CYCLES(150)) dut_a (
        .clock(clock), .reset(reset), .start(start), .instrValid(instrValid),
        .instrClass(instrClass), .branchTaken(branchTaken), .immTarget(immTarget),
        .regTarget(regTarget), .ioReady(ioReady), .flagPC(flag_a), .newAddress(addr_a),
        .pcReset(pcr_a), .busy(busy_a), .halted(halt_a), .illegal(ill_a)
    );

    pc_sequencer #(.ADDR_W(AW), .DELAY_CYCLES(1)) dut_b (
        .clock(clock), .reset(reset), .start(start), .instrValid(instrValid),
        .instrClass(instrClass), .branchTaken(branchTaken), .immTarget(immTarget),
        .regTarget(regTarget), .ioReady(ioReady), .flagPC(flag_b), .newAddress(addr_b),
        .pcReset(pcr_b), .busy(busy_b), .halted(halt_b), .illegal(ill_b)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", tag, $time, obs, expv);
        end
    endtask

    // Model: mode 0 idle, 1 run, 2 iowait, 3 settle, 4 halted. The settle exit is the
    // absolute edge number at which the increment must happen.
    int delay_of [2] = '{150, 1};
    int m_mode   [2];
    int m_ill    [2];
    int m_inc_at [2];
    int cyc = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k]   = 0;
            m_ill[k]    = 0;
            m_inc_at[k] = -1;
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_mode[k] = 0;
                m_ill[k]  = 0;
            end else begin
                case (m_mode[k])
                    0: if (start) begin m_mode[k] = 1; m_ill[k] = 0; end
                    1: if (instrValid) begin
                        if (instrClass == 3'd4) m_mode[k] = 4;
                        else if (instrClass == 3'd5) m_mode[k] = 2;
                        else if (instrClass >= 3'd6) m_ill[k] = 1;
                    end
                    2: if (ioReady) begin m_mode[k] = 3; m_inc_at[k] = cyc + delay_of[k]; end
                    3: if (cyc == m_inc_at[k]) m_mode[k] = 1;
                    default: if (start) m_mode[k] = 0;
                endcase
            end
        end
        cyc++;
    endtask

    task automatic check_inst(input int k, input logic [1:0] f, input logic [AW-1:0] a,
                              input logic pr, input logic b, input logic h, input logic il);
        logic [1:0]    ef;
        logic [AW-1:0] ea;
        string         p;
        ef = 2'd0;
        ea = '0;
        p  = (k == 0) ? "d150" : "d1";
        if (m_mode[k] == 1 && instrValid) begin
            case (instrClass)
                3'd1: begin ef = 2'd2; ea = immTarget; end
                3'd2: if (branchTaken) begin ef = 2'd2; ea = immTarget; end else ef = 2'd1;
                3'd3: begin ef = 2'd2; ea = regTarget; end
                3'd4, 3'd5: ef = 2'd0;
                default: ef = 2'd1;
            endcase
        end else if (m_mode[k] == 3 && cyc == m_inc_at[k]) begin
            ef = 2'd1;
        end
        chk({p, ".flagPC"},     32'(f),  32'(ef));
        chk({p, ".newAddress"}, 32'(a),  32'(ea));
        chk({p, ".pcReset"},    32'(pr), 32'(m_mode[k] == 0));
        chk({p, ".busy"},       32'(b),  32'(m_mode[k] >= 1 && m_mode[k] <= 3));
        chk({p, ".halted"},     32'(h),  32'(m_mode[k] == 4));
        chk({p, ".illegal"},    32'(il), 32'(m_ill[k]));
    endtask

    task automatic check_all();
        check_inst(0, flag_a, addr_a, pcr_a, busy_a, halt_a, ill_a);
        check_inst(1, flag_b, addr_b, pcr_b, busy_b, halt_b, ill_b);
    endtask

    task automatic step();
        @(negedge clock);
        check_all();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic instr(input logic v, input logic [2:0] c, input logic bt,
                         input logic [AW-1:0] imm, input logic [AW-1:0] rt);
        instrValid  = v;
        instrClass  = c;
        branchTaken = bt;
        immTarget   = imm;
        regTarget   = rt;
    endtask

    // Reset asserted between edges; outputs must reach reset values before the next edge.
    task automatic async_reset_pulse();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        step();
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;

        for (int i = 0; i < 4; i++) begin
            instr(1'b1, 3'd0, 1'b0, AW'($urandom), AW'($urandom));
            step();
        end
        instr(1'b1, 3'd1, 1'b0, 20'h00123, 20'h0);     step();
        instr(1'b1, 3'd2, 1'b0, 20'h00456, 20'h0);     step();
        instr(1'b1, 3'd2, 1'b1, 20'h54321, 20'h0);     step();
        instr(1'b1, 3'd3, 1'b0, 20'h0,     20'hFFFFF); step();
        instr(1'b0, 3'd1, 1'b1, 20'h11111, 20'h22222); step();

        instr(1'b1, 3'd5, 1'b0, 20'h0, 20'h0); step();
        instr(1'b0, 3'd0, 1'b0, 20'h0, 20'h0);
        step();
        step();
        ioReady = 1'b1; step();
        ioReady = 1'b0;
        for (int i = 0; i < 160; i++) step();

        instr(1'b1, 3'd4, 1'b0, 20'h0, 20'h0); step();
        for (int i = 0; i < 4; i++) begin
            instr(i[0], 3'($urandom), 1'b1, AW'($urandom), AW'($urandom));
            step();
        end
        instr(1'b0, 3'd0, 1'b0, 20'h0, 20'h0);
        start = 1'b1; step();
        start = 1'b0; step();
        start = 1'b1; step();
        start = 1'b0;

        instr(1'b1, 3'd7, 1'b0, 20'h0, 20'h0); step();
        for (int i = 0; i < 3; i++) begin
            instr(1'b1, 3'd0, 1'b0, 20'h0, 20'h0);
            step();
        end
        start = 1'b1; step();
        start = 1'b0;

        instr(1'b1, 3'd5, 1'b0, 20'h0, 20'h0);
        ioReady = 1'b1; step();
        instr(1'b0, 3'd0, 1'b0, 20'h0, 20'h0);
        step();
        ioReady = 1'b0;
        for (int i = 0; i < 80; i++) step();
        async_reset_pulse();
        start = 1'b1; step();
        start = 1'b0;
        instr(1'b1, 3'd5, 1'b0, 20'h0, 20'h0); step();
        instr(1'b0, 3'd0, 1'b0, 20'h0, 20'h0);
        ioReady = 1'b1; step();
        ioReady = 1'b0;
        for (int i = 0; i < 155; i++) step();

        for (int i = 0; i < 2000; i++) begin
            logic [2:0] c;
            c = 3'($urandom_range(0, 7));
            if ((c == 3'd4 || c >= 3'd6) && $urandom_range(0, 3) != 0) c = 3'd0;
            instr(1'($urandom), c, 1'($urandom), AW'($urandom), AW'($urandom));
            start   = ($urandom_range(0, 7) == 0);
            ioReady = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) async_reset_pulse();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control unit that drives the program counter's `flagPC`/`newAddress` inputs each cycle from the decoded instruction class.
- Sequences normal increment, jump, branch, jump-register, halt and I/O-wait with a fixed settle delay.
- Sits between the instruction decoder/branch comparator and the program counter, and owns the program counter's synchronous reset line.
- Replaces ad-hoc generation of `flagPC` in the control path.

## Interface
Parameters:
- `ADDR_W`, 20: width of instruction addresses; must match the program counter.
- `DELAY_CYCLES`, 150: settle cycles after an I/O ready event before advancing; legal range is ≥1.

Ports:
- `clock`  in  1: single system clock, rising edge.
- `reset`  in  1: asynchronous, active-high; returns the block to IDLE.
- `start`  in  1: begin execution from address 0, or restart after halt.
- `instrValid`  in  1: `instrClass`/targets are valid this cycle.
- `instrClass`  in  3: 0 SEQ, 1 JUMP, 2 BRANCH, 3 JREG, 4 HALT, 5 IOWAIT; 6–7 reserved.
- `branchTaken`  in  1: branch condition result, meaningful only with BRANCH.
- `immTarget`  in  ADDR_W: target for JUMP and taken BRANCH.
- `regTarget`  in  ADDR_W: target for JREG.
- `ioReady`  in  1: external I/O completion (data entered).
- `flagPC`  out  2: 0 hold, 1 increment, 2 load `newAddress`; 3 (PC-internal delay) is never driven.
- `newAddress`  out  ADDR_W: load target; 0 whenever `flagPC`≠2.
- `pcReset`  out  1: drives the program counter's synchronous reset.
- `busy`  out  1: high in RUN, IOWAIT and SETTLE.
- `halted`  out  1: high in HALTED.
- `illegal`  out  1: sticky reserved-class flag.

## Operation
- Registered state: IDLE, RUN, IOWAIT, SETTLE, HALTED, plus settle counter and `illegal`.
- Output decode is Mealy: `flagPC` and `newAddress` are combinational from state and current inputs. The program counter acts on them at the same edge.
- IDLE:
  - `pcReset`=1, `flagPC`=0.
  - `start` → RUN; `illegal` is cleared on this transition.
- RUN, with `instrValid`=0: `flagPC`=0 (stall) and the state is held.
- RUN, with `instrValid`=1:
  - SEQ: `flagPC`=1.
  - JUMP: `flagPC`=2, `newAddress`=`immTarget`.
  - BRANCH: taken → 2 with `immTarget`; not taken → 1.
  - JREG: `flagPC`=2, `newAddress`=`regTarget`.
  - HALT: `flagPC`=0, next state HALTED.
  - IOWAIT: `flagPC`=0, next state IOWAIT.
  - Reserved (6–7): treated as SEQ and sets `illegal`.
- `start` while in RUN, IOWAIT or SETTLE is ignored.
- IOWAIT:
  - `flagPC`=0.
  - `ioReady`=1 → SETTLE, with the counter loaded to 0.
  - The earliest `ioReady` acted upon is the cycle after entry, even if `ioReady` was already high on entry.
- SETTLE:
  - `flagPC`=0 while counter < `DELAY_CYCLES`-1; the counter increments each cycle.
  - At counter = `DELAY_CYCLES`-1: `flagPC`=1 and the next state is RUN.
  - `ioReady` is ignored.
- HALTED:
  - `flagPC`=0.
  - `start` → IDLE, which gives one `pcReset` cycle; a further `start` is then required to run.
- Counter width: clog2(`DELAY_CYCLES`+1). It never wraps because it is reloaded on SETTLE entry.

## Timing
- Reset values: state IDLE, `pcReset`=1, `flagPC`=0, `newAddress`=0, `busy`=0, `halted`=0, `illegal`=0, counter 0.
- Reset is asynchronous to assertion and takes effect in any state, including mid-SETTLE, where the counter clears.
- Zero-cycle decision latency: an instruction presented in cycle N changes the PC at edge N.
- Settle: with `ioReady` sampled high at edge E (state IOWAIT), the `flagPC`=1 increment occurs exactly `DELAY_CYCLES` edges later. No increment occurs earlier.
- The HALT and IOWAIT instructions themselves do not advance the PC. The PC still points at them during the wait, and SETTLE exit performs the single advance.
- `start` in IDLE: RUN from the next cycle; `pcReset` deasserts in the same cycle as the transition.

## Structure
- Package `pc_seq_pkg` holds:
  - state enum (3-bit);
  - instruction-class localparams (CLS_SEQ…CLS_IOWAIT);
  - flagPC localparams (PC_HOLD=0, PC_INC=1, PC_LOAD=2).
- Sub-module `pc_settle_timer` (parameter `DELAY_CYCLES`):
  - inputs: `load`, `enable`;
  - output: `done`, high when count = `DELAY_CYCLES`-1.
- Top: state register, next-state/output decode, sticky `illegal`.

## Test plan
- Reset then `start`: `pcReset`=1 until the `start` edge, then RUN. Then 4× SEQ with `instrValid`=1 → `flagPC`=1 on each of the 4 cycles.
- JUMP with `immTarget`=0x00123 → `flagPC`=2, `newAddress`=0x00123 that cycle. Then BRANCH with `branchTaken`=0 → `flagPC`=1, `newAddress`=0. JREG with `regTarget`=0xFFFFF → load 0xFFFFF.
- IOWAIT, `ioReady` high 3 cycles later, `DELAY_CYCLES`=150:
  - `flagPC`=0 for 149 SETTLE cycles, then exactly one cycle of `flagPC`=1, then RUN.
  - A repeat with `DELAY_CYCLES`=1 gives the increment on the first SETTLE cycle.
- HALT → `halted`=1, `flagPC`=0 with `instrValid` toggling. `start` → IDLE with `pcReset`=1 for one cycle. `start` → RUN.
- Reserved class 7 in RUN → `flagPC`=1 and `illegal` rises and stays high through later SEQ instructions. It is cleared only by reset or IDLE→RUN.
- Asynchronous `reset` pulse mid-SETTLE (counter at 80), between clock edges → immediate IDLE with all outputs at their reset values. Restart and a second IOWAIT take the full 150 cycles.
